// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit asynchronous SRAM between the video fetcher
// (V, read-only, priority) and the CPU (C, read/write). Each access runs for a
// fixed number of ACCESS clocks and then one DONE clock that carries the ack.
// A burst limit lets C in after MAX_VIDEO_BURST consecutive V grants made
// while C was waiting.
module sram_arbiter #(
    parameter int unsigned ACCESS_CYCLES   = 2,
    parameter int unsigned MAX_VIDEO_BURST = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_req,
    input  logic [20:0] v_addr,
    output logic        v_ack,
    output logic [7:0]  v_rdata,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [20:0] c_addr,
    input  logic [7:0]  c_wdata,
    output logic        c_ack,
    output logic [7:0]  c_rdata,
    output logic [20:0] sram_addr,
    input  logic [7:0]  sram_data_in,
    output logic [7:0]  sram_data_out,
    output logic        sram_data_oe,
    output logic        sram_we_n,
    output logic        busy
);

    localparam int unsigned ADDR_W = 21;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [CNT_W-1:0]  burst_q, burst_d;
    logic              gnt_c_q, gnt_c_d;
    logic              gnt_we_q, gnt_we_d;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d;
    logic              oe_d;
    logic              we_n_d;
    logic              v_ack_d, c_ack_d;
    logic [DATA_W-1:0] v_rdata_d, c_rdata_d;
    logic              busy_d;

    logic              c_wins_c;
    logic              last_cyc_c;

    // Arbitration: C only wins when V is absent or the V burst limit is reached
    assign c_wins_c   = c_req && (!v_req || (burst_q == CNT_W'(MAX_VIDEO_BURST)));
    assign last_cyc_c = (cyc_q == CNT_W'(ACCESS_CYCLES - 1));

    // Next-state and next-output computation for every registered output
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        burst_d   = burst_q;
        gnt_c_d   = gnt_c_q;
        gnt_we_d  = gnt_we_q;
        addr_d    = sram_addr;
        dout_d    = sram_data_out;
        oe_d      = sram_data_oe;
        we_n_d    = 1'b1;
        v_ack_d   = 1'b0;
        c_ack_d   = 1'b0;
        v_rdata_d = v_rdata;
        c_rdata_d = c_rdata;

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                if (v_req || c_req) begin
                    state_d = ACCESS;
                    cyc_d   = '0;
                    if (c_wins_c) begin
                        gnt_c_d  = 1'b1;
                        gnt_we_d = c_we;
                        addr_d   = c_addr;
                        dout_d   = c_wdata;
                        oe_d     = c_we;
                        burst_d  = '0;
                    end else begin
                        gnt_c_d  = 1'b0;
                        gnt_we_d = 1'b0;
                        addr_d   = v_addr;
                        burst_d  = c_req ? (burst_q + CNT_W'(1)) : '0;
                    end
                end
            end
            ACCESS: begin
                if (last_cyc_c) begin
                    // WE rises here while oe stays up so write data is held into DONE
                    state_d = DONE;
                    if (gnt_c_q) begin
                        c_ack_d = 1'b1;
                        if (!gnt_we_q) begin
                            c_rdata_d = sram_data_in;
                        end
                    end else begin
                        v_ack_d   = 1'b1;
                        v_rdata_d = sram_data_in;
                    end
                end else begin
                    cyc_d  = cyc_q + CNT_W'(1);
                    we_n_d = ~gnt_we_q;
                end
            end
            DONE: begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                oe_d    = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset forces the bus safe immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cyc_q         <= '0;
            burst_q       <= '0;
            gnt_c_q       <= 1'b0;
            gnt_we_q      <= 1'b0;
            sram_addr     <= '0;
            sram_data_out <= '0;
            sram_data_oe  <= 1'b0;
            sram_we_n     <= 1'b1;
            v_ack         <= 1'b0;
            c_ack         <= 1'b0;
            v_rdata       <= '0;
            c_rdata       <= '0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            burst_q       <= burst_d;
            gnt_c_q       <= gnt_c_d;
            gnt_we_q      <= gnt_we_d;
            sram_addr     <= addr_d;
            sram_data_out <= dout_d;
            sram_data_oe  <= oe_d;
            sram_we_n     <= we_n_d;
            v_ack         <= v_ack_d;
            c_ack         <= c_ack_d;
            v_rdata       <= v_rdata_d;
            c_rdata       <= c_rdata_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed CPU/video transactions with an SRAM model
// and a scoreboard of expected acknowledges checked by a monitor.
module tb_sram_arbiter;

    localparam int unsigned A  = 2;
    localparam int unsigned MB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_req;
    logic [20:0] v_addr;
    logic        v_ack;
    logic [7:0]  v_rdata;
    logic        c_req;
    logic        c_we;
    logic [20:0] c_addr;
    logic [7:0]  c_wdata;
    logic        c_ack;
    logic [7:0]  c_rdata;
    logic [20:0] sram_addr;
    logic [7:0]  sram_data_in;
    logic [7:0]  sram_data_out;
    logic        sram_data_oe;
    logic        sram_we_n;
    logic        busy;

    sram_arbiter #(.ACCESS_CYCLES(A), .MAX_VIDEO_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .v_req(v_req), .v_addr(v_addr), .v_ack(v_ack), .v_rdata(v_rdata),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_data_out(sram_data_out), .sram_data_oe(sram_data_oe),
        .sram_we_n(sram_we_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM model: combinational read, write on clock edges while WE is low
    logic [7:0] mem [256];
    assign sram_data_in = mem[sram_addr[7:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_data_oe) mem[sram_addr[7:0]] <= sram_data_out;
    end

    typedef struct {
        logic       is_c;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_c = 8'h00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: every ack pops one scoreboard entry and checks port and data
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && (v_ack || c_ack)) begin
            chk("ack_excl", 32'(v_ack && c_ack), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(c_ack), 32'(e.is_c));
                if (e.is_c) chk("c_rdata", 32'(c_rdata), 32'(e.data));
                else        chk("v_rdata", 32'(v_rdata), 32'(e.data));
            end
        end
    end

    // One CPU access with per-cycle bus checks; starts and ends at a negedge
    task automatic cpu_access(input logic we, input logic [20:0] addr,
                              input logic [7:0] wdata, input logic [7:0] exp_rd);
        exp_t e;
        int   n;
        if (!we) last_c = exp_rd;
        e.is_c = 1'b1;
        e.data = last_c;
        sb.push_back(e);
        c_we = we; c_addr = addr; c_wdata = wdata; c_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n <= int'(A)) begin
                chk("acc_addr", 32'(sram_addr), 32'(addr));
                chk("acc_oe", 32'(sram_data_oe), 32'(we));
                chk("acc_we_n", 32'(sram_we_n), 32'(!(we && n > 1)));
                if (we) chk("acc_dout", 32'(sram_data_out), 32'(wdata));
            end
        end while (!c_ack && n < 20);
        chk("c_latency", 32'(n), 32'(A + 1));
        if (we) chk("done_oe_hold", 32'(sram_data_oe), 32'd1);
        chk("done_we_n", 32'(sram_we_n), 32'd1);
        c_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   acks;
        int   cyc;
        int   last_t;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n = 1'b0;
        v_req = 1'b0; v_addr = '0;
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_data_oe), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_dout", 32'(sram_data_out), 32'd0);
        chk("rst_acks", 32'({v_ack, c_ack}), 32'd0);
        chk("rst_rdata", 32'({v_rdata, c_rdata}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // CPU write then read back through the SRAM model
        cpu_access(1'b1, 21'h008FD5, 8'hA5, 8'h00);
        @(negedge clk);
        chk("idle_oe", 32'(sram_data_oe), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("mem_written", 32'(mem[8'hD5]), 32'h0A5);
        mem[8'h23] = 8'h3C;
        cpu_access(1'b0, 21'h000123, 8'h00, 8'h3C);
        @(negedge clk);
        chk("c_rdata_hold", 32'(c_rdata), 32'h03C);

        // Both requesting continuously: V,V,V,C,V,V,V,C
        mem[8'h40] = 8'h5A;
        mem[8'h41] = 8'h11;
        for (int k = 0; k < 8; k++) begin
            e.is_c = ((k % 4) == 3);
            e.data = e.is_c ? 8'h5A : 8'h11;
            sb.push_back(e);
        end
        last_c = 8'h5A;
        c_we = 1'b0; c_addr = 21'h000040; v_addr = 21'h100041;
        v_req = 1'b1; c_req = 1'b1;
        acks = 0; cyc = 0;
        while (acks < 8 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (v_ack || c_ack) acks++;
        end
        v_req = 1'b0; c_req = 1'b0;
        chk("burst_acks", 32'(acks), 32'd8);
        @(negedge clk);
        chk("burst_sb_drain", 32'(sb.size()), 32'd0);

        // V alone back-to-back: one ack every A+2 clocks, C never acked
        for (int k = 0; k < 4; k++) begin
            e.is_c = 1'b0;
            e.data = 8'h11;
            sb.push_back(e);
        end
        v_req = 1'b1;
        acks = 0; cyc = 0; last_t = 0;
        while (acks < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (v_ack) begin
                if (acks == 0) chk("v_latency", 32'(cyc), 32'(A + 1));
                else           chk("v_spacing", 32'(cyc - last_t), 32'(A + 2));
                chk("v_burst_cnt", 32'(dut.burst_q), 32'd0);
                last_t = cyc;
                acks++;
            end
        end
        v_req = 1'b0;
        chk("v_acks", 32'(acks), 32'd4);

        // Reset on ACCESS clock 1 of a write aborts with no ack
        @(negedge clk);
        c_we = 1'b1; c_addr = 21'h000050; c_wdata = 8'hC3; c_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_we_n", 32'(sram_we_n), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_oe", 32'(sram_data_oe), 32'd0);
        c_req = 1'b0;
        last_c = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_no_ack", 32'({v_ack, c_ack}), 32'd0);
        end
        chk("abort_mem", 32'(mem[8'h50]), 32'd0);
        chk("abort_rdata", 32'(c_rdata), 32'd0);

        // Req held past ack starts a second access; late addr change waits for it
        mem[8'h60] = 8'h77;
        mem[8'h61] = 8'h99;
        e.is_c = 1'b1; e.data = 8'h77; sb.push_back(e);
        e.is_c = 1'b1; e.data = 8'h99; sb.push_back(e);
        last_c = 8'h99;
        c_we = 1'b0; c_addr = 21'h000060; c_req = 1'b1;
        @(negedge clk);
        chk("rep_addr0", 32'(sram_addr), 32'h060);
        c_addr = 21'h000061;
        @(negedge clk);
        chk("rep_addr1", 32'(sram_addr), 32'h060);
        @(negedge clk);
        chk("rep_ack1", 32'(c_ack), 32'd1);
        @(negedge clk);
        chk("rep_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("rep_addr2", 32'(sram_addr), 32'h061);
        chk("rep_busy2", 32'(busy), 32'd1);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!c_ack && cyc < 20);
        c_req = 1'b0;
        chk("rep_latency2", 32'(cyc), 32'(A));
        repeat (3) @(negedge clk);
        chk("final_sb_drain", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 8-bit asynchronous SRAM between two requesters: the video fetcher (port V, priority) and the CPU (port C, read/write).
- Sits between the requesters and the SRAM pins.
- Takes bus ownership once the power-on configuration read has released it.
- Sequences fixed-length SRAM cycles, generates sram_we_n, and returns read data with a one-cycle acknowledge pulse.

Parameters:
- ACCESS_CYCLES, 2, clocks the SRAM address/data are held per access; legal range 2..15.
- MAX_VIDEO_BURST, 3, consecutive V grants allowed while C is waiting before C is forced in; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- v_req  in  1  video request (read only); level, held until v_ack.
- v_addr  in  21  video address.
- v_ack  out  1  one-cycle pulse; v_rdata valid in this cycle.
- v_rdata  out  8  video read data.
- c_req  in  1  CPU request; level, held until c_ack.
- c_we  in  1  1 = write, 0 = read.
- c_addr  in  21  CPU address.
- c_wdata  in  8  CPU write data.
- c_ack  out  1  one-cycle pulse; c_rdata valid in this cycle for reads.
- c_rdata  out  8  CPU read data.
- sram_addr  out  21  SRAM address.
- sram_data_in  in  8  SRAM data pins (input side).
- sram_data_out  out  8  SRAM write data.
- sram_data_oe  out  1  1 = drive SRAM data pins.
- sram_we_n  out  1  SRAM write enable, active low.
- busy  out  1  high while not IDLE.

Behaviour:
- Reset values: state IDLE; sram_we_n=1; sram_data_oe=0; sram_addr=0; sram_data_out=0; both acks 0; both rdata 0; burst counter 0; cycle counter 0; busy 0.
- Reset is asynchronous: assertion mid-access aborts at once, with sram_we_n high and oe low immediately. No ack is ever issued for the aborted access.
- All outputs are registered.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples requests each clock.
  - If any request is pending, arbitrate (rules below), latch the winner's addr/we/wdata into the output registers, and go to ACCESS with the cycle counter at 0.
  - With no request, stay in IDLE; sram_addr holds its last value, we_n=1, oe=0.
- ACCESS:
  - Lasts exactly ACCESS_CYCLES clocks; sram_addr is stable throughout.
  - Write: oe=1 and data stable for the whole state. sram_we_n=0 on ACCESS clocks 1..ACCESS_CYCLES-1 and 1 on clock 0, so address setup precedes the WE fall.
  - At the edge ending the last ACCESS clock: we_n returns to 1 in the same edge, oe stays 1 into DONE (data hold), and the FSM goes to DONE.
  - Read: oe=0 and we_n=1 throughout. At the edge ending the last ACCESS clock, sram_data_in is captured into the winner's rdata and the FSM goes to DONE.
- DONE:
  - Lasts one clock; the winner's ack=1; oe=0 at exit.
  - Then IDLE.
  - rdata holds until that port's next read completes.
- Latency: request seen in IDLE at cycle t → ack in cycle t+ACCESS_CYCLES+1. Peak rate is one access per ACCESS_CYCLES+2 clocks.
- Handshake: a requester must drop req by the clock edge ending its ack cycle; req still high in the following IDLE is a new request. Changing addr/wdata/we after the grant has no effect.
- Arbitration:
  - V wins by default.
  - The burst counter increments on each V grant made while c_req is high, and clears on any C grant or whenever c_req is low at a grant.
  - When the counter equals MAX_VIDEO_BURST and c_req is high, C wins even if v_req is high.
  - Simultaneous requests with counter below the limit → V.
- Only one access is in flight; no queueing.

Test Plan:
- Reset then C write (c_addr=21'h008FD5, c_wdata=8'hA5) with ACCESS_CYCLES=2:
  - sram_addr=008FD5 and oe=1 for 2 ACCESS clocks.
  - we_n high on clock 0, low on clock 1.
  - c_ack pulses exactly 3 clocks after req is sampled.
- C read with SRAM model returning 8'h3C → c_rdata=8'h3C during the c_ack pulse, with we_n=1 and oe=0 throughout.
- v_req and c_req held high continuously, MAX_VIDEO_BURST=3 → grant sequence V,V,V,C,V,V,V,C…; v_ack and c_ack are never in the same cycle.
- v_req alone, back-to-back → one v_ack every 4 clocks; burst counter stays 0; c_ack never asserted.
- rst_n asserted on ACCESS clock 1 of a write → we_n=1 and oe=0 within the same cycle (asynchronously); after release, busy=0 and no ack is seen for the aborted access.
- Requester keeps req high one cycle past ack → a second access of the same type starts and is acknowledged; addr changed after the grant is ignored until the next grant.
